// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with bypass and clear sweep
// Reads are registered; a sequential sweep zeroes the array after reset or on clr_req.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [$clog2(NREG)-1:0]         wr_addr,
  input  logic [XLEN-1:0]                 wr_data,
  input  logic [NRD*$clog2(NREG)-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]             rd_data,
  input  logic                            clr_req,
  output logic                            clr_busy,
  output logic                            clr_done,
  output logic                            wr_drop
);

  localparam int              AW     = $clog2(NREG);
  localparam logic [AW:0]     NREG_W = (AW+1)'(NREG);
  localparam logic [AW-1:0]   LAST   = AW'(NREG-1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          cnt_q, cnt_d;
  logic                   wr_drop_q, wr_drop_d;
  logic [NRD*XLEN-1:0]    rd_data_q, rd_data_d;
  logic [XLEN-1:0]        mem_q [NREG];

  logic                   mem_we;
  logic [AW-1:0]          mem_waddr;
  logic [XLEN-1:0]        mem_wdata;
  logic                   busy;
  logic                   wr_in_range;
  logic                   wr_is_zero;
  logic                   wr_accept;

  assign busy        = (state_q == S_CLEAR);
  assign wr_in_range = ({1'b0, wr_addr} < NREG_W);
  assign wr_is_zero  = ZERO_REG && (wr_addr == '0);
  assign wr_accept   = wr_en && !busy && wr_in_range && !wr_is_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
      rd_data_q <= rd_data_d;
    end
  end

  // The array has no reset: the clear sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra        = '0;
    clr_done  = busy && (cnt_q == LAST);
    wr_drop_d = wr_en && (busy || !wr_in_range);
    mem_we    = busy || wr_accept;
    mem_waddr = busy ? cnt_q : wr_addr;
    mem_wdata = busy ? '0 : wr_data;
    rd_data_d = '0;
    // Write-first bypass only for writes that actually land in the array.
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      if (busy || !({1'b0, ra} < NREG_W) || (ZERO_REG && (ra == '0))) begin
        rd_data_d[k*XLEN +: XLEN] = '0;
      end else if (wr_accept && (wr_addr == ra)) begin
        rd_data_d[k*XLEN +: XLEN] = wr_data;
      end else begin
        rd_data_d[k*XLEN +: XLEN] = mem_q[ra];
      end
    end
  end

  assign clr_busy = busy;
  assign wr_drop  = wr_drop_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
// Three instances: zero-reg, ordinary reg 0, and NREG=24/NRD=3.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic        clr_req;
  logic [63:0] rd_data_a, rd_data_b;
  logic        clr_busy_a, clr_done_a, wr_drop_a;
  logic        clr_busy_b, clr_done_b, wr_drop_b;

  logic        rst_n_c;
  logic        wr_en_c;
  logic [4:0]  wr_addr_c;
  logic [31:0] wr_data_c;
  logic [14:0] rd_addr_c;
  logic        clr_req_c;
  logic [95:0] rd_data_c;
  logic        clr_busy_c, clr_done_c, wr_drop_c;

  int n_cmp;
  int n_err;
  int busy_cnt, done_cnt, done_at;

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .clr_req(clr_req),
    .clr_busy(clr_busy_a), .clr_done(clr_done_a), .wr_drop(wr_drop_a)
  );

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .clr_req(clr_req),
    .clr_busy(clr_busy_b), .clr_done(clr_done_b), .wr_drop(wr_drop_b)
  );

  regfile_mp #(.XLEN(32), .NREG(24), .NRD(3), .ZERO_REG(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .rd_addr(rd_addr_c), .rd_data(rd_data_c), .clr_req(clr_req_c),
    .clr_busy(clr_busy_c), .clr_done(clr_done_c), .wr_drop(wr_drop_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; clr_req = 1'b0;
    rst_n_c = 1'b0; wr_en_c = 1'b0; wr_addr_c = '0; wr_data_c = '0; rd_addr_c = '0; clr_req_c = 1'b0;
    tick(); tick();

    chk("reset_rd_data", rd_data_a, 64'h0);
    chk("reset_busy_done_drop", {clr_busy_a, clr_done_a, wr_drop_a}, 3'b100);
    chk("reset_c_busy_rd", {clr_busy_c, rd_data_c}, {1'b1, 96'h0});

    rst_n = 1'b1; rst_n_c = 1'b1;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int i = 0; i < 100 && clr_busy_a; i++) begin
      busy_cnt++;
      if (clr_done_a) begin done_cnt++; done_at = busy_cnt; end
      tick();
    end
    chk("init_busy_cycles", busy_cnt, 32);
    chk("init_done_count", done_cnt, 1);
    chk("init_done_cycle", done_at, 32);
    chk("init_c_idle", clr_busy_c, 1'b0);

    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      tick();
      chk($sformatf("init_zero_a_%0d", a), rd_data_a, 64'h0);
      chk($sformatf("init_zero_b_%0d", a), rd_data_b, 64'h0);
    end

    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd1, 5'd2};
    tick();
    wr_en = 1'b0; rd_addr = {5'd5, 5'd5};
    tick();
    chk("x5_both_ports_a", rd_data_a, {32'hDEADBEEF, 32'hDEADBEEF});
    chk("x5_both_ports_b", rd_data_b, {32'hDEADBEEF, 32'hDEADBEEF});

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; rd_addr = {5'd7, 5'd6};
    tick();
    chk("bypass_x7_a", rd_data_a, {32'h12345678, 32'h0});
    chk("bypass_x7_b", rd_data_b, {32'h12345678, 32'h0});

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr = {5'd0, 5'd0};
    tick();
    wr_en = 1'b0;
    chk("x0_bypass_a", rd_data_a, 64'h0);
    chk("x0_bypass_b", rd_data_b, {32'hFFFFFFFF, 32'hFFFFFFFF});
    chk("x0_no_drop", {wr_drop_a, wr_drop_b}, 2'b00);
    tick();
    chk("x0_read_a", rd_data_a, 64'h0);
    chk("x0_read_b", rd_data_b, {32'hFFFFFFFF, 32'hFFFFFFFF});

    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
      tick();
    end
    wr_en = 1'b0; rd_addr = {5'd3, 5'd31};
    tick();
    chk("fill_readback", rd_data_a, {32'd3, 32'd31});

    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_req_busy", clr_busy_a, 1'b1);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int i = 0; i < 100 && clr_busy_a; i++) begin
      busy_cnt++;
      if (clr_done_a) begin done_cnt++; done_at = busy_cnt; end
      wr_en = (i == 0) || clr_done_a; wr_addr = 5'd3; wr_data = 32'd99;
      clr_req = (i == 5);
      tick();
      if (i == 0) chk("clear_wr_drop", wr_drop_a, 1'b1);
      if (i == 1) chk("clear_wr_drop_pulse", wr_drop_a, 1'b0);
      if (i == 2) chk("clear_reads_zero", rd_data_a, 64'h0);
    end
    clr_req = 1'b0;
    chk("clear_busy_cycles", busy_cnt, 32);
    chk("clear_done_cycle", {done_cnt, done_at}, {32'd1, 32'd32});
    chk("last_clear_cycle_drop", wr_drop_a, 1'b1);

    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5; rd_addr = {5'd3, 5'd9};
    tick();
    wr_en = 1'b0;
    chk("first_idle_write", {wr_drop_a, rd_data_a}, {1'b0, 32'h0, 32'hA5});
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      tick();
      chk($sformatf("post_clear_a_%0d", a), rd_data_a, (a == 8) ? {32'hA5, 32'h0} : 64'h0);
      chk($sformatf("post_clear_b_%0d", a), rd_data_b, (a == 8) ? {32'hA5, 32'h0} : 64'h0);
    end

    wr_en_c = 1'b1; wr_addr_c = 5'd30; wr_data_c = 32'h55; rd_addr_c = {5'd31, 5'd30, 5'd30};
    tick();
    chk("c_oob_drop", wr_drop_c, 1'b1);
    chk("c_oob_read", rd_data_c, 96'h0);
    wr_addr_c = 5'd24;
    tick();
    chk("c_addr24_drop", wr_drop_c, 1'b1);
    wr_addr_c = 5'd23; wr_data_c = 32'h77;
    tick();
    wr_en_c = 1'b0; rd_addr_c = {5'd23, 5'd23, 5'd23};
    chk("c_x23_accept", wr_drop_c, 1'b0);
    tick();
    chk("c_x23_read", rd_data_c, {32'h77, 32'h77, 32'h77});

    clr_req_c = 1'b1;
    tick();
    clr_req_c = 1'b0;
    repeat (10) tick();
    rst_n_c = 1'b0;
    tick();
    chk("c_mid_reset", {clr_busy_c, clr_done_c, wr_drop_c, rd_data_c}, {3'b100, 96'h0});
    rst_n_c = 1'b1;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int i = 0; i < 100 && clr_busy_c; i++) begin
      busy_cnt++;
      if (clr_done_c) begin done_cnt++; done_at = busy_cnt; end
      tick();
    end
    chk("c_restart_busy", busy_cnt, 24);
    chk("c_restart_done", {done_cnt, done_at}, {32'd1, 32'd24});
    tick();
    chk("c_x23_cleared", rd_data_c, 96'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file, the next generation of the single-write/dual-read integer register file in the RISC-V core datapath. Adds configurable word width, register count and read-port count, same-cycle write-to-read bypass, optional hardwired-zero register, and a sequential clear engine that runs after reset or on request. Sits between decode (read addresses) and writeback (write port); read data is registered for the execute stage.

## Interface

- XLEN, 32: data word width in bits.
- NREG, 32: number of registers (2..256, need not be a power of two).
- NRD, 2: number of read ports (1..4).
- ZERO_REG, 1: 1 means register 0 always reads 0 and ignores writes; 0 means register 0 is ordinary.
- AW, derived as clog2(NREG): address width; not to be overridden.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- rd_addr  in  NRD*AW  packed read addresses; port k at bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  packed registered read data; port k at bits [k*XLEN +: XLEN].
- clr_req  in  1  request a full clear (single-cycle pulse or level).
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse on the last clear cycle.
- wr_drop  out  1  one-cycle pulse: a write was discarded (during clear or address >= NREG).

## Operation

- FSM states: CLEAR, IDLE. Reset (rst_n low) forces CLEAR, clear counter = 0.
- CLEAR: each cycle writes 0 to R[cnt], cnt increments; on cnt == NREG-1 the write completes, clr_done = 1 that cycle, next state IDLE. Duration exactly NREG cycles.
- IDLE: clr_req = 1 at a rising edge -> CLEAR next cycle with cnt = 0. clr_req during CLEAR is ignored (no restart, no extension).
- Writes: in IDLE, wr_en = 1 with wr_addr < NREG and not (ZERO_REG and wr_addr == 0) writes R[wr_addr] at the rising edge.
- wr_en = 1 during CLEAR, or with wr_addr >= NREG: write discarded, wr_drop = 1 next cycle. Write to address 0 with ZERO_REG = 1: silently ignored, no wr_drop.
- Reads, per port k, registered: rd_data[k] <= value for rd_addr[k] at each rising edge:
  - 0 if clr_busy, or rd_addr[k] >= NREG, or (ZERO_REG and rd_addr[k] == 0);
  - else wr_data if an accepted write to the same address occurs in the same cycle (bypass, write-first);
  - else R[rd_addr[k]].
- All read ports independent; any ports may share an address.

## Timing

- Reset values: rd_data = 0, clr_busy = 1, clr_done = 0, wr_drop = 0, FSM = CLEAR, cnt = 0. Array contents are not reset directly; the clear sweep zeroes them.
- After rst_n deassertion: clr_busy stays 1 for NREG rising edges; clr_done pulses on the NREG-th; clr_busy = 0 from the following cycle.
- clr_busy is a registered output = (state == CLEAR).
- Read latency: 1 cycle from rd_addr to rd_data. Write-to-read: 0 extra cycles via bypass.
- rst_n asserted mid-clear or mid-operation: immediate return to reset values; the sweep restarts from register 0.
- Last clear cycle together with wr_en: write dropped (still CLEAR). A write in the first IDLE cycle is accepted.

## Test plan

- Reset release with NREG=32: clr_busy high exactly 32 cycles, clr_done single pulse on cycle 32; then every address reads 0 on both ports.
- Write 0xDEADBEEF to x5, next cycle read x5 on port 0 and port 1 -> both return 0xDEADBEEF one cycle later.
- Same-cycle write 0x12345678 to x7 and read x7 on port 1 -> rd_data port 1 = 0x12345678 next cycle (bypass); port 0 reading x6 unaffected.
- ZERO_REG=1: write 0xFFFFFFFF to x0 -> read x0 returns 0, wr_drop stays 0. ZERO_REG=0: same write reads back 0xFFFFFFFF.
- Fill x1..x31 with their index, pulse clr_req, issue wr_en to x3 during clear -> wr_drop pulses, reads return 0 while busy, all registers read 0 after clr_done.
- NREG=24, NRD=3: write to address 30 -> wr_drop pulse; read of address 30 returns 0; rst_n low for 1 cycle at clear count 10 -> sweep restarts, 24 busy cycles after release.
